// File: rtl/saturn_bus_pkg.sv
// rtl/saturn_bus_pkg.sv - shared phase encodings, FSM states and entry layout for the Saturn bus sequencer
package saturn_bus_pkg;

  localparam int DEF_PROG_DEPTH = 32;
  localparam int DEF_NIBBLE_W   = 4;
  localparam int DEF_RD_CNT_W   = 5;

  localparam logic [3:0] PH_SEND   = 4'b0001;
  localparam logic [3:0] PH_READ   = 4'b0010;
  localparam logic [3:0] PH_DECODE = 4'b0100;
  localparam logic [3:0] PH_EXEC   = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_READ = 2'd2
  } bus_state_t;

  // Queue entries are {cmd_flag, nibble}; the flag sits just above the nibble.
  localparam int CMD_FLAG = DEF_NIBBLE_W;

  function automatic int cmd_flag_bit(input int nibble_w);
    return nibble_w;
  endfunction

endpackage

// File: rtl/saturn_bus_fifo.sv
// rtl/saturn_bus_fifo.sv - circular command/data queue with registered level, full and empty
module saturn_bus_fifo
  import saturn_bus_pkg::*;
#(
  parameter int DEPTH = DEF_PROG_DEPTH,
  parameter int WIDTH = DEF_NIBBLE_W + 1
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign o_full  = (o_level == LW'(DEPTH));
  assign o_empty = (o_level == '0);
  assign o_head  = mem[rd_ptr];
  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_level <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   o_level <= o_level + LW'(1);
        2'b01:   o_level <= o_level - LW'(1);
        default: o_level <= o_level;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/saturn_bus_sequencer.sv
// rtl/saturn_bus_sequencer.sv - nibble-bus sequencer: queued sends, counted read bursts; SATURN_BUS_PHASE_CHECK_EN adds phase fault detection
module saturn_bus_sequencer
  import saturn_bus_pkg::*;
#(
  parameter int PROG_DEPTH = DEF_PROG_DEPTH,
  parameter int NIBBLE_W   = DEF_NIBBLE_W,
  parameter int RD_CNT_W   = DEF_RD_CNT_W
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic [3:0]                    i_phases,
  input  logic                          i_debug_cycle,
  input  logic                          i_cmd_valid,
  input  logic [NIBBLE_W:0]             i_cmd_data,
  output logic                          o_cmd_ready,
  input  logic                          i_rd_req,
  input  logic [RD_CNT_W-1:0]           i_rd_count,
  output logic                          o_rd_valid,
  output logic [NIBBLE_W-1:0]           o_rd_nibble,
  output logic                          o_bus_clk_en,
  output logic                          o_bus_is_data,
  output logic [NIBBLE_W-1:0]           o_bus_nibble_out,
  input  logic [NIBBLE_W-1:0]           i_bus_nibble_in,
  output logic [$clog2(PROG_DEPTH):0]   o_level,
  output logic                          o_busy,
  output logic                          o_error
);

  localparam int ENT_W = NIBBLE_W + 1;
  localparam int FLAG  = cmd_flag_bit(NIBBLE_W);

  bus_state_t          state;
  logic [RD_CNT_W-1:0] rd_remaining;
  logic [ENT_W-1:0]    head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                do_pop;
  logic                advance;
  logic                rd_dec;
  logic                final_dec;
  logic                rd_busy;
  logic                frozen;
  logic                phase_fault;

`ifdef SATURN_BUS_PHASE_CHECK_EN
  assign phase_fault = !i_debug_cycle && !frozen &&
                       ((i_phases == '0) || ((i_phases & (i_phases - 4'd1)) != '0));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)       frozen <= 1'b0;
    else if (phase_fault) frozen <= 1'b1;
  end
`else
  assign phase_fault = 1'b0;
  assign frozen      = 1'b0;
`endif

  assign o_cmd_ready = !fifo_full;
  assign advance     = !i_debug_cycle && !frozen && !phase_fault;
  assign do_pop      = advance && (i_phases == PH_SEND) && !fifo_empty;
  assign rd_dec      = advance && (i_phases == PH_READ) && (state == S_READ) && (rd_remaining != '0);
  assign final_dec   = rd_dec && (rd_remaining == RD_CNT_W'(1));
  // A request landing on the last capture is treated as arriving after it.
  assign rd_busy     = (rd_remaining != '0) && !final_dec;

  saturn_bus_fifo #(
    .DEPTH (PROG_DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_push      (i_cmd_valid),
    .i_push_data (i_cmd_data),
    .i_pop       (do_pop),
    .o_head      (head),
    .o_level     (o_level),
    .o_full      (fifo_full),
    .o_empty     (fifo_empty)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state            <= S_IDLE;
      rd_remaining     <= '0;
      o_bus_clk_en     <= 1'b0;
      o_bus_is_data    <= 1'b0;
      o_bus_nibble_out <= '0;
      o_rd_valid       <= 1'b0;
      o_rd_nibble      <= '0;
      o_busy           <= 1'b1;
      o_error          <= 1'b0;
    end else begin
      o_rd_valid <= 1'b0;
      if (phase_fault || frozen) o_bus_clk_en <= 1'b0;
      if (phase_fault)           o_error      <= 1'b1;

      if (advance) begin
        case (i_phases)
          PH_SEND: begin
            if (!fifo_empty) begin
              o_bus_nibble_out <= head[NIBBLE_W-1:0];
              o_bus_is_data    <= !head[FLAG];
              o_bus_clk_en     <= 1'b1;
              o_busy           <= 1'b1;
              state            <= S_SEND;
            end else if (rd_remaining != '0) begin
              o_bus_clk_en <= 1'b1;
              o_busy       <= 1'b1;
              state        <= S_READ;
            end else begin
              state <= S_IDLE;
            end
          end
          PH_READ: begin
            o_bus_clk_en <= 1'b0;
            if (rd_dec) begin
              o_rd_nibble <= i_bus_nibble_in;
              o_rd_valid  <= 1'b1;
            end
          end
          PH_DECODE: begin
            if (fifo_empty && (rd_remaining == '0)) begin
              o_busy <= 1'b0;
              state  <= S_IDLE;
            end
          end
          default: ;
        endcase
      end

      if (i_rd_req && !rd_busy) rd_remaining <= i_rd_count;
      else if (rd_dec)          rd_remaining <= rd_remaining - RD_CNT_W'(1);
      if (i_rd_req && rd_busy)  o_error <= 1'b1;
    end
  end

endmodule
